// File: rtl/xvga_timing_gen_pkg.sv
// Shared 1024x768 raster timing constants and helpers.
// Count widths, default porch/sync geometry, derived sync windows.
package display_timing_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int FCOUNT_W = 16;

  localparam int XVGA_H_ACTIVE = 1024;
  localparam int XVGA_H_FP     = 24;
  localparam int XVGA_H_SYNC   = 136;
  localparam int XVGA_H_BP     = 160;
  localparam int XVGA_H_TOTAL  = XVGA_H_ACTIVE + XVGA_H_FP
                               + XVGA_H_SYNC + XVGA_H_BP;

  localparam int XVGA_V_ACTIVE = 768;
  localparam int XVGA_V_FP     = 3;
  localparam int XVGA_V_SYNC   = 6;
  localparam int XVGA_V_BP     = 29;
  localparam int XVGA_V_TOTAL  = XVGA_V_ACTIVE + XVGA_V_FP
                               + XVGA_V_SYNC + XVGA_V_BP;

  localparam int HSYNC_START = XVGA_H_ACTIVE + XVGA_H_FP;
  localparam int HSYNC_END   = HSYNC_START + XVGA_H_SYNC;
  localparam int VSYNC_START = XVGA_V_ACTIVE + XVGA_V_FP;
  localparam int VSYNC_END   = VSYNC_START + XVGA_V_SYNC;

  // Maps "inside the sync window" onto the pin level.
  function automatic logic sync_drive(
    input logic asserted,
    input bit   active_low
  );
    return asserted ^ active_low;
  endfunction

endpackage

// File: rtl/xvga_timing_gen_if.sv
// Raster timing bundle from the generator to display consumers.
// master drives counts/syncs/blank/strobes; slave observes them.
interface xvga_timing_gen_if;
  import display_timing_pkg::*;

  logic [HCOUNT_W-1:0] hcount;
  logic [VCOUNT_W-1:0] vcount;
  logic                hsync;
  logic                vsync;
  logic                blank;
  logic                line_start;
  logic                frame_start;
  logic [FCOUNT_W-1:0] frame_count;

  modport master (
    output hcount, vcount, hsync, vsync, blank,
    output line_start, frame_start, frame_count
  );

  modport slave (
    input hcount, vcount, hsync, vsync, blank,
    input line_start, frame_start, frame_count
  );
endinterface

// File: rtl/xvga_timing_gen_sync_axis_counter.sv
// One raster axis: wrapping counter plus sync/blank decode.
// Ports: clk, rst_n, step in; count, wrap, in_sync, in_blank out.
module sync_axis_counter #(
  parameter int ACTIVE = 1024,
  parameter int FP     = 24,
  parameter int SYNC   = 136,
  parameter int BP     = 160,
  parameter int W      = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         in_sync,
  output logic         in_blank
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam int S0    = ACTIVE + FP;
  localparam int S1    = S0 + SYNC;
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  if (TOTAL > 2**W || TOTAL < 1) begin : g_bad_total
    $error("sync_axis_counter: total %0d exceeds %0d bits",
           TOTAL, W);
  end

  logic [W-1:0] nxt;
  logic [31:0]  nxt32;

  assign wrap = step && (count == LAST);

  always_comb begin
    nxt = count;
    if (step) nxt = wrap ? '0 : count + W'(1);
  end

  // Decode describes the value count takes at the next edge,
  // so the owner can register it alongside the count.
  assign nxt32    = 32'(nxt);
  assign in_sync  = (nxt32 >= 32'(S0)) && (nxt32 < 32'(S1));
  assign in_blank = nxt32 >= 32'(ACTIVE);

  always_ff @(posedge clk) begin
    if (!rst_n) count <= '0;
    else        count <= nxt;
  end

endmodule

// File: rtl/xvga_timing_gen.sv
// XVGA raster timing source: counts, syncs, blank, strobes.
// Ports: vclock, reset (sync, active-low), en; vid (master).
module xvga_timing_gen
  import display_timing_pkg::*;
#(
  parameter int H_ACTIVE        = XVGA_H_ACTIVE,
  parameter int H_FP            = XVGA_H_FP,
  parameter int H_SYNC          = XVGA_H_SYNC,
  parameter int H_BP            = XVGA_H_BP,
  parameter int V_ACTIVE        = XVGA_V_ACTIVE,
  parameter int V_FP            = XVGA_V_FP,
  parameter int V_SYNC          = XVGA_V_SYNC,
  parameter int V_BP            = XVGA_V_BP,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic              vclock,
  input  logic              reset,
  input  logic              en,
  xvga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2**HCOUNT_W || V_TOTAL > 2**VCOUNT_W)
  begin : g_bad_geometry
    $error("xvga_timing_gen: totals %0d/%0d overflow counts",
           H_TOTAL, V_TOTAL);
  end

  logic [HCOUNT_W-1:0] h_count;
  logic [VCOUNT_W-1:0] v_count;
  logic                h_wrap;
  logic                v_wrap;
  logic                h_in_sync;
  logic                v_in_sync;
  logic                h_in_blank;
  logic                v_in_blank;

  logic                hsync_q;
  logic                vsync_q;
  logic                blank_q;
  logic                line_q;
  logic                frame_q;
  logic [FCOUNT_W-1:0] fcount_q;

  sync_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (HCOUNT_W)
  ) u_h (
    .clk      (vclock),
    .rst_n    (reset),
    .step     (en),
    .count    (h_count),
    .wrap     (h_wrap),
    .in_sync  (h_in_sync),
    .in_blank (h_in_blank)
  );

  // Vertical advances only on the horizontal wrap, so vsync
  // can only change when hcount presents 0.
  sync_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (VCOUNT_W)
  ) u_v (
    .clk      (vclock),
    .rst_n    (reset),
    .step     (en && h_wrap),
    .count    (v_count),
    .wrap     (v_wrap),
    .in_sync  (v_in_sync),
    .in_blank (v_in_blank)
  );

  always_ff @(posedge vclock) begin
    if (!reset) begin
      hsync_q  <= SYNC_ACTIVE_LOW;
      vsync_q  <= SYNC_ACTIVE_LOW;
      blank_q  <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      fcount_q <= '0;
    end else begin
      hsync_q <= sync_drive(h_in_sync, SYNC_ACTIVE_LOW);
      vsync_q <= sync_drive(v_in_sync, SYNC_ACTIVE_LOW);
      blank_q <= h_in_blank || v_in_blank;
      line_q  <= h_wrap;
      frame_q <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) fcount_q <= fcount_q + 1'b1;
    end
  end

  assign vid.hcount      = h_count;
  assign vid.vcount      = v_count;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.blank       = blank_q;
  assign vid.line_start  = line_q;
  assign vid.frame_start = frame_q;
  assign vid.frame_count = fcount_q;

endmodule

// File: doc/xvga_timing_gen.md
Name: xvga_timing_gen

Overview:
Generates the 1024x768 raster timing that all display-side blocks consume: hcount, vcount, hsync, vsync and blank, plus frame and line strobes. It sits at the source end of the display pipeline. The game and draw blocks consume its outputs and delay the syncs to match their own pixel latency. All outputs are registered and mutually consistent in every cycle.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels); H_TOTAL = 1344
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines); V_TOTAL = 806
SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync driven low while asserted

Ports:
vclock  in  1  pixel clock; sole clock
reset  in  1  synchronous, active-low reset (0 = reset)
en  in  1  pixel-advance enable; counters hold when 0
hcount  out  11  horizontal index, 0..H_TOTAL-1
vcount  out  10  vertical index, 0..V_TOTAL-1
hsync  out  1  horizontal sync (polarity per SYNC_ACTIVE_LOW)
vsync  out  1  vertical sync (polarity per SYNC_ACTIVE_LOW)
blank  out  1  1 = outside the visible area
line_start  out  1  one-cycle pulse when hcount enters 0
frame_start  out  1  one-cycle pulse when (hcount,vcount) enters (0,0)
frame_count  out  16  frames completed since reset, modulo 2^16

Behaviour:
- Reset (reset==0 at vclock edge): hcount=0, vcount=0, blank=0, hsync/vsync inactive (1 if SYNC_ACTIVE_LOW), line_start=0, frame_start=0, frame_count=0. Reset overrides en. No strobe fires in the cycle leaving reset.
- Advance, only on cycles with en==1:
  - If hcount==H_TOTAL-1, hcount becomes 0; otherwise hcount increments.
  - On the hcount wrap: if vcount==V_TOTAL-1, vcount becomes 0; otherwise vcount increments.
- Hold, on cycles with en==0: hcount, vcount, hsync, vsync, blank and frame_count keep their values; line_start=0 and frame_start=0.
- Decode is computed from the next counter values and registered with them, so the decoded outputs always match the presented hcount/vcount with zero relative latency:
  - blank = (hcount >= H_ACTIVE) || (vcount >= V_ACTIVE).
  - hsync asserted for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 1048..1183.
  - vsync asserted for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 771..776. vsync changes only together with a vcount change, which happens at hcount=0.
- Strobes:
  - line_start=1 in the cycle where hcount presents 0 after a wrap.
  - frame_start=1 in the cycle where (0,0) is presented after a frame wrap. frame_count increments in that same cycle.
  - frame_count wraps from 16'hFFFF to 0.
- Arithmetic: unsigned; counter widths are fixed by the ports. Parameter sums must fit those widths (H_TOTAL <= 2048, V_TOTAL <= 1024); this is checked by an elaboration-time assertion.
- Reset mid-frame: on the next edge every output takes its reset value and the raster restarts at (0,0).

Decomposition:
- Package display_timing_pkg holds:
  - the default timing constants (XVGA_H_ACTIVE, ..., V_TOTAL);
  - derived constants HSYNC_START/END and VSYNC_START/END;
  - the count widths (HCOUNT_W=11, VCOUNT_W=10).
- One sub-module, sync_axis_counter, is instantiated twice:
  - Parameters: ACTIVE, FP, SYNC, BP, W.
  - Inputs: step.
  - Outputs: count, wrap, in_sync, in_blank.
  - The horizontal instance steps on en. The vertical instance steps on en && horizontal wrap.

Test Plan:
- Reset held 3 cycles, then released with en=1 -> hcount=0, vcount=0, hsync=vsync=1, blank=0, frame_count=0, no strobe in the release cycle. hcount=1 on the next cycle.
- Run one line -> blank rises at hcount=1024. hsync=0 exactly for hcount 1048..1183. At 1343->0, vcount goes 0->1 and line_start pulses for 1 cycle.
- Run to vcount=805, hcount=1343, then one cycle -> (0,0), frame_start=1 for 1 cycle, frame_count 0->1. vsync=0 exactly for vcount 771..776, changing only at hcount=0.
- Toggle en=0 for 5 cycles at hcount=1343, vcount=805 -> all outputs frozen and no strobes. The wrap and frame_start occur on the first en=1 cycle.
- Assert reset at hcount=500, vcount=300 with en=1 -> next edge gives all reset values. Raster restarts; no frame_start until the next full frame.
- Force frame_count to 16'hFFFF (or run a shortened-parameter instance with H_TOTAL=8, V_TOTAL=4) through one frame wrap -> frame_count=0 and frame_start pulses.
